// File: rtl/dds_phase_accumulator.sv
// Phase accumulator for the DDS path: programmable increment/offset applied at wrap, sync resync, AXI-stream output.
// Optional LFSR output dither is compiled in with `define DDS_PHASE_DITHER_EN.
module dds_phase_accumulator #(
    parameter int unsigned PHASE_WIDTH  = 48,
    parameter int unsigned DITHER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic [PHASE_WIDTH-1:0] cfg_phase_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_phase_off,
    input  logic                   cfg_update,
    input  logic                   sync_in,
    output logic [PHASE_WIDTH-1:0] m_axis_tdata_phase,
    output logic                   m_axis_tvalid_phase,
    input  logic                   m_axis_tready_phase,
    output logic                   wrap,
    output logic                   update_pending,
    output logic [PHASE_WIDTH-1:0] active_inc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [PHASE_WIDTH-1:0] r_acc;
    logic [PHASE_WIDTH-1:0] r_active_inc;
    logic [PHASE_WIDTH-1:0] r_active_off;
    logic [PHASE_WIDTH-1:0] r_pend_inc;
    logic [PHASE_WIDTH-1:0] r_pend_off;
    logic [PHASE_WIDTH-1:0] r_tdata;
    logic                   r_tvalid;
    logic                   r_wrap;

    logic                   w_advance;
    logic [PHASE_WIDTH:0]   w_sum;
    logic                   w_carry;
    logic [PHASE_WIDTH-1:0] w_beat;
    logic                   w_load_cfg;
    logic                   w_load_pend;
    logic                   w_latch_pend;

    // The dither source is a 16-bit LFSR, so wider dither fields are not meaningful.
    if (DITHER_WIDTH > 16) begin : g_dither_width_exceeds_lfsr
    end

    assign w_advance = enable && (!r_tvalid || m_axis_tready_phase);
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_active_inc};
    assign w_carry   = w_sum[PHASE_WIDTH];

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0]            r_lfsr;
    logic                   w_lfsr_fb;
    logic [PHASE_WIDTH-1:0] w_dither;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_dither  = PHASE_WIDTH'(r_lfsr[DITHER_WIDTH-1:0]);
    assign w_beat    = r_acc + r_active_off + w_dither;

    always_ff @(posedge clk) begin
        if (!aresetn || sync_in) begin
            r_lfsr <= 16'hACE1;
        end else if (w_advance) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_beat = r_acc + r_active_off;
`endif

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the strobes that move config between cfg_*, pending and active registers.
    always_comb begin
        w_state_next = r_state;
        w_load_cfg   = 1'b0;
        w_load_pend  = 1'b0;
        w_latch_pend = 1'b0;
        if (sync_in) begin
            if (cfg_update) begin
                w_load_cfg = 1'b1;
            end else if (r_state == ST_ARMED) begin
                w_load_pend = 1'b1;
            end
            w_state_next = enable ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_load_cfg = cfg_update;
                    if (enable) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cfg_update) begin
                        w_latch_pend = 1'b1;
                        w_state_next = ST_ARMED;
                    end else if (!enable && (!r_tvalid || m_axis_tready_phase)) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    // A cfg_update coinciding with the apply point wins over the older pending values.
                    if ((w_advance && w_carry) || !enable) begin
                        w_load_cfg   = cfg_update;
                        w_load_pend  = !cfg_update;
                        w_state_next = enable ? ST_RUN : ST_IDLE;
                    end else if (cfg_update) begin
                        w_latch_pend = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_acc        <= '0;
            r_active_inc <= '0;
            r_active_off <= '0;
            r_pend_inc   <= '0;
            r_pend_off   <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            if (w_load_cfg) begin
                r_active_inc <= cfg_phase_inc;
                r_active_off <= cfg_phase_off;
            end else if (w_load_pend) begin
                r_active_inc <= r_pend_inc;
                r_active_off <= r_pend_off;
            end
            if (w_latch_pend) begin
                r_pend_inc <= cfg_phase_inc;
                r_pend_off <= cfg_phase_off;
            end

            // Sync suppresses beat generation for one cycle so the next emitted beat starts at the offset.
            if (sync_in) begin
                r_acc  <= '0;
                r_wrap <= 1'b0;
                if (r_tvalid && m_axis_tready_phase) begin
                    r_tvalid <= 1'b0;
                end
            end else if (w_advance) begin
                r_tdata  <= w_beat;
                r_acc    <= w_sum[PHASE_WIDTH-1:0];
                r_tvalid <= 1'b1;
                r_wrap   <= w_carry;
            end else begin
                r_wrap <= 1'b0;
                if (r_tvalid && m_axis_tready_phase) begin
                    r_tvalid <= 1'b0;
                end
            end
        end
    end

    assign m_axis_tdata_phase  = r_tdata;
    assign m_axis_tvalid_phase = r_tvalid;
    assign wrap                = r_wrap;
    assign update_pending      = (r_state == ST_ARMED);
    assign active_inc          = r_active_inc;

endmodule
